avalon_uart: RTL

Avalon-MM responder implementing an 8N1 UART with TX and RX FIFOs, attached to the SoC's `uart0_avn_*` slave port in place of the current tie-off. The core reaches it over the data bus; the bus decoder forwards `uart0_avn_*` and this block returns `readdata` and `waitrequest`. Serial pins `uart_txd` and `uart_rxd` go to the SoC top level.

---
 rtl/avalon_uart_pkg.sv | 30 +++
 rtl/uart_sync_fifo.sv | 45 ++++
 rtl/avalon_uart.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/avalon_uart_pkg.sv
// rtl/avalon_uart_pkg.sv - register map, bit positions and FSM state type for avalon_uart
package avalon_uart_pkg;

    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_DIV    = 3'd4;

    localparam int CTRL_TXEN = 0;
    localparam int CTRL_RXEN = 1;
    localparam int CTRL_TXIE = 2;
    localparam int CTRL_RXIE = 3;

    localparam int STAT_OVERRUN = 4;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through FIFO with extra-bit wrap pointers
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/avalon_uart.sv
// rtl/avalon_uart.sv - Avalon-MM 8N1 UART with TX/RX FIFOs and level interrupt
module avalon_uart
    import avalon_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        avn_read,
    input  logic        avn_write,
    input  logic [4:0]  avn_address,
    input  logic [3:0]  avn_byte_enable,
    input  logic [31:0] avn_writedata,
    output logic [31:0] avn_readdata,
    output logic        avn_waitrequest,
    output logic        uart_txd,
    input  logic        uart_rxd,
    output logic        uart_irq
);

    logic [2:0]  reg_idx;
    logic [3:0]  ctrl;
    logic [15:0] div_reg;
    logic        overrun;
    logic        rd_ack;
    logic        rx_pop_pend;
    logic [31:0] rd_data;
    logic        unused_bits;

    logic        tx_push, tx_pop, tx_full, tx_empty, tx_take;
    logic [7:0]  tx_dout;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_dout;

    uart_state_e tx_state, rx_state;
    logic [15:0] tx_cnt, rx_cnt;
    logic [7:0]  tx_shift, rx_shift;
    logic [2:0]  tx_idx, rx_idx;
    logic [1:0]  rx_sync;
    logic        rxs, rxs_d;
    logic [16:0] div_p1;
    logic [15:0] half_m1;
    logic [15:0] div_wr;

    assign reg_idx         = avn_address[4:2];
    assign unused_bits     = ^{avn_address[1:0], avn_byte_enable[3:2], avn_writedata[31:16]};
    assign avn_waitrequest = avn_read & ~rd_ack;

    assign tx_push = avn_write && (reg_idx == REG_TXDATA) && avn_byte_enable[0];
    assign tx_take = ctrl[CTRL_TXEN] & ~tx_empty &
                     ((tx_state == UART_IDLE) || ((tx_state == UART_STOP) && (tx_cnt == 16'd0)));
    assign tx_pop  = tx_take;

    assign rxs     = rx_sync[1];
    assign rx_push = (rx_state == UART_STOP) && (rx_cnt == 16'd0) && rxs;
    assign rx_pop  = rd_ack & rx_pop_pend;
    assign div_p1  = {1'b0, div_reg} + 17'd1;
    assign half_m1 = div_p1[16:1] - 16'd1;
    assign div_wr  = {avn_byte_enable[1] ? avn_writedata[15:8] : div_reg[15:8],
                      avn_byte_enable[0] ? avn_writedata[7:0]  : div_reg[7:0]};

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(avn_writedata[7:0]),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_shift),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        rd_data = 32'd0;
        case (reg_idx)
            REG_TXDATA: rd_data = {tx_full, 31'd0};
            REG_RXDATA: rd_data = {rx_empty, 23'd0, rx_empty ? 8'd0 : rx_dout};
            REG_CTRL:   rd_data = {28'd0, ctrl};
            REG_STATUS: rd_data = {26'd0, (tx_state != UART_IDLE), overrun,
                                   rx_empty, rx_full, tx_empty, tx_full};
            REG_DIV:    rd_data = {16'd0, div_reg};
            default:    rd_data = 32'd0;
        endcase
    end

    // Readdata is captured in the stall cycle; the RX pop is deferred to the completing cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avn_readdata <= 32'd0;
            rd_ack       <= 1'b0;
            rx_pop_pend  <= 1'b0;
            ctrl         <= 4'd0;
            div_reg      <= DIV_RESET;
            overrun      <= 1'b0;
            uart_irq     <= 1'b0;
        end else begin
            rd_ack <= avn_read & ~rd_ack;
            if (avn_read && !rd_ack) begin
                avn_readdata <= rd_data;
                rx_pop_pend  <= (reg_idx == REG_RXDATA) && !rx_empty;
            end
            if (avn_write && avn_byte_enable[0] && reg_idx == REG_CTRL)
                ctrl <= avn_writedata[3:0];
            if (avn_write && (|avn_byte_enable[1:0]) && reg_idx == REG_DIV)
                div_reg <= clamp_div(div_wr);
            if (rx_push && rx_full && !rx_pop)
                overrun <= 1'b1;
            else if (avn_write && avn_byte_enable[0] && reg_idx == REG_STATUS &&
                     avn_writedata[STAT_OVERRUN])
                overrun <= 1'b0;
            uart_irq <= (ctrl[CTRL_TXIE] & tx_empty) | (ctrl[CTRL_RXIE] & ~rx_empty);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= UART_IDLE;
            tx_cnt   <= 16'd0;
            tx_shift <= 8'd0;
            tx_idx   <= 3'd0;
            uart_txd <= 1'b1;
        end else begin
            case (tx_state)
                UART_IDLE: if (tx_take) begin
                    tx_state <= UART_START;
                    uart_txd <= 1'b0;
                    tx_shift <= tx_dout;
                    tx_cnt   <= div_reg;
                    tx_idx   <= 3'd0;
                end
                UART_START: if (tx_cnt == 16'd0) begin
                    tx_state <= UART_DATA;
                    uart_txd <= tx_shift[0];
                    tx_cnt   <= div_reg;
                end else tx_cnt <= tx_cnt - 16'd1;
                UART_DATA: if (tx_cnt == 16'd0) begin
                    tx_cnt <= div_reg;
                    if (tx_idx == 3'd7) begin
                        tx_state <= UART_STOP;
                        uart_txd <= 1'b1;
                    end else begin
                        tx_idx   <= tx_idx + 3'd1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        uart_txd <= tx_shift[1];
                    end
                end else tx_cnt <= tx_cnt - 16'd1;
                UART_STOP: if (tx_cnt == 16'd0) begin
                    if (tx_take) begin
                        tx_state <= UART_START;
                        uart_txd <= 1'b0;
                        tx_shift <= tx_dout;
                        tx_cnt   <= div_reg;
                        tx_idx   <= 3'd0;
                    end else tx_state <= UART_IDLE;
                end else tx_cnt <= tx_cnt - 16'd1;
                default: tx_state <= UART_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rxs_d    <= 1'b1;
            rx_state <= UART_IDLE;
            rx_cnt   <= 16'd0;
            rx_shift <= 8'd0;
            rx_idx   <= 3'd0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rxd};
            rxs_d   <= rxs;
            case (rx_state)
                UART_IDLE: if (ctrl[CTRL_RXEN] && rxs_d && !rxs) begin
                    rx_state <= UART_START;
                    rx_cnt   <= half_m1;
                end
                UART_START: if (rx_cnt == 16'd0) begin
                    rx_state <= rxs ? UART_IDLE : UART_DATA;
                    rx_cnt   <= div_reg;
                    rx_idx   <= 3'd0;
                end else rx_cnt <= rx_cnt - 16'd1;
                UART_DATA: if (rx_cnt == 16'd0) begin
                    rx_shift <= {rxs, rx_shift[7:1]};
                    rx_cnt   <= div_reg;
                    if (rx_idx == 3'd7) rx_state <= UART_STOP;
                    else                rx_idx   <= rx_idx + 3'd1;
                end else rx_cnt <= rx_cnt - 16'd1;
                UART_STOP: if (rx_cnt == 16'd0) rx_state <= UART_IDLE;
                else rx_cnt <= rx_cnt - 16'd1;
                default: rx_state <= UART_IDLE;
            endcase
        end
    end

endmodule
